// File: rtl/pre_i_lcu_sched.sv
// pre_i_lcu_sched: walks a frame in LCU raster order for the pre-intra
// mode-decision controller. It loads LCU pixels into a ping-pong buffer one
// LCU ahead of the controller, gates the controller enable, retires each LCU
// on its finish pulse, and flags LCUs whose newblock count is wrong.
module pre_i_lcu_sched #(
  parameter int POS_W       = 7,
  parameter int BLK_PER_LCU = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [POS_W-1:0] lcu_cols,
  input  logic [POS_W-1:0] lcu_rows,
  output logic             ld_req,
  output logic [POS_W-1:0] ld_x,
  output logic [POS_W-1:0] ld_y,
  output logic             ld_slot,
  input  logic             ld_done,
  output logic             ctrl_enable,
  input  logic             ctrl_newblock,
  input  logic             ctrl_finish,
  output logic             run_slot,
  output logic [POS_W-1:0] run_x,
  output logic [POS_W-1:0] run_y,
  output logic             lcu_done,
  output logic             frame_done,
  output logic             busy,
  output logic             blk_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    RUN       = 2'd2,
    WAIT_LOAD = 2'd3
  } state_t;

  localparam logic [POS_W-1:0] ONE      = POS_W'(1);
  localparam logic [6:0]       CNT_MAX  = 7'h7f;
  localparam logic [6:0]       BLK_EXP  = 7'(BLK_PER_LCU);

  state_t           state;
  state_t           state_next;

  logic [POS_W-1:0] cols;
  logic [POS_W-1:0] rows;
  logic             ld_pend;     // a load has been requested and not yet acknowledged
  logic [1:0]       loaded;      // per-slot: buffer holds an LCU not yet retired
  logic [6:0]       blk_cnt;

  logic             ld_ack;
  logic             fin;
  logic             run_last;
  logic             ld_has_next;
  logic             other_rdy;
  logic             issue;
  logic [POS_W-1:0] cols_m1;
  logic [POS_W-1:0] rows_m1;
  logic [POS_W-1:0] run_nx;
  logic [POS_W-1:0] run_ny;
  logic [POS_W-1:0] ld_nx;
  logic [POS_W-1:0] ld_ny;
  logic [6:0]       cnt_inc;

  assign busy = (state != IDLE);

  // Decode of handshake events, raster successors and next state.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path through the block can leave one holding its old value (a latch).
    state_next  = state;
    cols_m1     = cols - ONE;
    rows_m1     = rows - ONE;
    ld_ack      = ld_done && ld_pend;
    fin         = (state == RUN) && ctrl_enable && ctrl_finish;
    run_last    = (run_x == cols_m1) && (run_y == rows_m1);
    run_nx      = (run_x == cols_m1) ? '0 : run_x + ONE;
    run_ny      = (run_x == cols_m1) ? run_y + ONE : run_y;
    ld_nx       = (ld_x == cols_m1) ? '0 : ld_x + ONE;
    ld_ny       = (ld_x == cols_m1) ? ld_y + ONE : ld_y;
    ld_has_next = !((ld_x == cols_m1) && (ld_y == rows_m1));
    // A load landing in the same cycle as finish counts as ready, so the
    // next LCU starts without a detour through WAIT_LOAD.
    other_rdy   = loaded[~run_slot] || (ld_ack && (ld_slot != run_slot));
    // Prefetch: one load outstanding at most, and only into a freed slot.
    issue       = (state != IDLE) && (!ld_pend || ld_ack) && ld_has_next &&
                  !loaded[~ld_slot];
    cnt_inc     = (ctrl_newblock && (blk_cnt != CNT_MAX)) ? blk_cnt + 7'd1 : blk_cnt;

    case (state)
      IDLE:      if (start)  state_next = FILL;
      FILL:      if (ld_ack) state_next = RUN;
      RUN: begin
        if (fin) begin
          if (run_last)       state_next = IDLE;
          else if (other_rdy) state_next = RUN;
          else                state_next = WAIT_LOAD;
        end
      end
      WAIT_LOAD: if (ld_ack) state_next = RUN;
      default:   state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers are updated with <= so every flop samples the values
    // from before this edge, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Load, run and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols        <= '0;
      rows        <= '0;
      ld_req      <= 1'b0;
      ld_x        <= '0;
      ld_y        <= '0;
      ld_slot     <= 1'b0;
      ld_pend     <= 1'b0;
      loaded      <= 2'b00;
      ctrl_enable <= 1'b0;
      run_slot    <= 1'b0;
      run_x       <= '0;
      run_y       <= '0;
      blk_cnt     <= '0;
      lcu_done    <= 1'b0;
      frame_done  <= 1'b0;
      blk_err     <= 1'b0;
    end else begin
      ld_req     <= 1'b0;
      lcu_done   <= 1'b0;
      frame_done <= 1'b0;

      if (ld_ack) begin
        loaded[ld_slot] <= 1'b1;
        ld_pend         <= 1'b0;
      end
      if (issue) begin
        ld_req  <= 1'b1;
        ld_x    <= ld_nx;
        ld_y    <= ld_ny;
        ld_slot <= ~ld_slot;
        ld_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cols     <= lcu_cols;
            rows     <= lcu_rows;
            blk_err  <= 1'b0;
            ld_req   <= 1'b1;
            ld_x     <= '0;
            ld_y     <= '0;
            ld_slot  <= 1'b0;
            ld_pend  <= 1'b1;
            loaded   <= 2'b00;
            run_slot <= 1'b0;
            run_x    <= '0;
            run_y    <= '0;
            blk_cnt  <= '0;
          end
        end
        FILL: begin
          if (ld_ack) ctrl_enable <= 1'b1;
        end
        RUN: begin
          if (!ctrl_enable) begin
            // Single idle cycle between back-to-back LCUs.
            ctrl_enable <= 1'b1;
          end else if (ctrl_finish) begin
            ctrl_enable      <= 1'b0;
            lcu_done         <= 1'b1;
            blk_err          <= blk_err | (cnt_inc != BLK_EXP);
            blk_cnt          <= '0;
            loaded[run_slot] <= 1'b0;
            if (run_last) begin
              frame_done <= 1'b1;
            end else if (other_rdy) begin
              run_slot <= ~run_slot;
              run_x    <= run_nx;
              run_y    <= run_ny;
            end
          end else begin
            blk_cnt <= cnt_inc;
          end
        end
        WAIT_LOAD: begin
          if (ld_ack) begin
            ctrl_enable <= 1'b1;
            run_slot    <= ~run_slot;
            run_x       <= run_nx;
            run_y       <= run_ny;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pre_i_lcu_sched.sv
// Bench for pre_i_lcu_sched: behavioural fetch unit and controller, with a
// scoreboard of expected loads and LCU retirements checked by a monitor.
module tb_pre_i_lcu_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] lcu_cols;
  logic [6:0] lcu_rows;
  logic       ld_req;
  logic [6:0] ld_x;
  logic [6:0] ld_y;
  logic       ld_slot;
  logic       ld_done;
  logic       ctrl_enable;
  logic       ctrl_newblock;
  logic       ctrl_finish;
  logic       run_slot;
  logic [6:0] run_x;
  logic [6:0] run_y;
  logic       lcu_done;
  logic       frame_done;
  logic       busy;
  logic       blk_err;

  pre_i_lcu_sched #(.POS_W(7), .BLK_PER_LCU(65)) dut (
    .clk(clk), .rst(rst), .start(start),
    .lcu_cols(lcu_cols), .lcu_rows(lcu_rows),
    .ld_req(ld_req), .ld_x(ld_x), .ld_y(ld_y), .ld_slot(ld_slot), .ld_done(ld_done),
    .ctrl_enable(ctrl_enable), .ctrl_newblock(ctrl_newblock), .ctrl_finish(ctrl_finish),
    .run_slot(run_slot), .run_x(run_x), .run_y(run_y),
    .lcu_done(lcu_done), .frame_done(frame_done), .busy(busy), .blk_err(blk_err)
  );

  int total = 0;
  int bad   = 0;

  logic [14:0] exp_ld[$];    // {x, y, slot}
  logic [2:0]  exp_done[$];  // {frame_done, blk_err, busy}
  int          nb_q[$];      // newblocks the controller emits per LCU
  int          gaps[$];      // observed enable-low run lengths between LCUs

  int ld_lat  = 1;
  int ld_mode = 0;  // 0 fixed latency, 1 done with finish, 2 done 200 cycles after finish

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Fetch unit model: answers each ld_req with a one-cycle ld_done.
  bit fa_abort;
  bit fa_first;
  int fa_k;
  initial begin : fetch_model
    ld_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      ld_done = 1'b0;
      if (!rst && ld_req) begin
        fa_abort = 1'b0;
        fa_first = (ld_x == 7'd0) && (ld_y == 7'd0);
        if (fa_first || ld_mode == 0) begin
          for (int i = 0; i < ld_lat && !fa_abort; i++) begin
            @(posedge clk); #2;
            if (rst) fa_abort = 1'b1;
          end
        end else begin
          fa_k = 0;
          while (!ctrl_finish && !fa_abort) begin
            @(posedge clk); #2;
            fa_k++;
            if (rst) fa_abort = 1'b1;
            else if (fa_k > 3000) begin
              check("fetch_finish_wait", ctrl_finish, 1);
              fa_abort = 1'b1;
            end
          end
          if (ld_mode == 2) begin
            for (int i = 0; i < 200 && !fa_abort; i++) begin
              @(posedge clk); #2;
              if (rst) fa_abort = 1'b1;
            end
          end
        end
        if (!fa_abort) ld_done = 1'b1;
      end
    end
  end

  // Controller model: two cycles after enable, N newblocks, then finish.
  int ctl_phase;
  int ctl_nb;
  initial begin : ctrl_model
    ctrl_newblock = 1'b0;
    ctrl_finish   = 1'b0;
    ctl_phase     = 0;
    ctl_nb        = 65;
    forever begin
      @(posedge clk); #1;
      ctrl_newblock = 1'b0;
      ctrl_finish   = 1'b0;
      if (rst || !ctrl_enable) begin
        ctl_phase = 0;
      end else begin
        ctl_phase++;
        if (ctl_phase == 1) begin
          if (nb_q.size() != 0) ctl_nb = nb_q.pop_front();
          else                  ctl_nb = 65;
        end
        if (ctl_phase >= 3 && ctl_phase < 3 + ctl_nb) ctrl_newblock = 1'b1;
        else if (ctl_phase == 3 + ctl_nb)             ctrl_finish   = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops on ld_req / lcu_done, and enable-gap tracking.
  logic [14:0] m_ld;
  logic [2:0]  m_done;
  bit          en_seen = 1'b0;
  int          gap = 0;
  always @(negedge clk) begin
    if (ld_req) begin
      check("ld_req_queue", exp_ld.size() != 0, 1);
      if (exp_ld.size() != 0) begin
        m_ld = exp_ld.pop_front();
        check("ld_req_pos_slot", {ld_x, ld_y, ld_slot}, m_ld);
      end
    end
    if (lcu_done) begin
      check("lcu_done_queue", exp_done.size() != 0, 1);
      if (exp_done.size() != 0) begin
        m_done = exp_done.pop_front();
        check("lcu_done_fd_err_busy", {frame_done, blk_err, busy}, m_done);
      end
    end else if (frame_done) begin
      check("frame_done_with_lcu_done", lcu_done, 1);
    end
    if (!busy) begin
      en_seen = 1'b0;
      gap     = 0;
    end else if (ctrl_enable) begin
      if (en_seen && gap > 0) gaps.push_back(gap);
      en_seen = 1'b1;
      gap     = 0;
    end else if (en_seen) begin
      gap++;
    end
  end

  task automatic push_frame_exp(input int cols, input int rows, input int err_idx);
    logic s;
    int   n;
    s = 1'b0;
    n = 0;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < cols; x++) begin
        exp_ld.push_back({7'(x), 7'(y), s});
        s = ~s;
        exp_done.push_back({(n == cols * rows - 1), (n >= err_idx), (n != cols * rows - 1)});
        n++;
      end
    end
  endtask

  task automatic pulse_start(input int cols, input int rows);
    @(posedge clk); #1;
    start    = 1'b1;
    lcu_cols = 7'(cols);
    lcu_rows = 7'(rows);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int cols, input int rows, input int err_idx);
    int n;
    gaps.delete();
    push_frame_exp(cols, rows, err_idx);
    pulse_start(cols, rows);
    check("blk_err_cleared_by_start", blk_err, 0);
    check("busy_after_start", busy, 1);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      check("frame_complete", busy, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ld.delete();
      exp_done.delete();
      nb_q.delete();
    end
    @(negedge clk); #1;
    check("ld_queue_drained", exp_ld.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
  endtask

  task automatic check_gaps(input int n_exp, input int len);
    check("gap_count", gaps.size(), n_exp);
    foreach (gaps[i]) check("gap_len", gaps[i], len);
  endtask

  function automatic logic [63:0] out_vec();
    return {28'd0, ld_req, ld_x, ld_y, ld_slot, ctrl_enable, run_slot, run_x, run_y,
            lcu_done, frame_done, busy, blk_err};
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    lcu_cols = '0;
    lcu_rows = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 0);
    rst = 1'b0;

    // 1x1 frame, slow load: one load, frame_done with lcu_done, no prefetch.
    ld_lat = 5;
    run_frame(1, 1, 1000);
    check_gaps(0, 1);

    // 3x2 frame, fast loads: raster order, alternating slots, one-cycle gaps.
    ld_lat = 1;
    run_frame(3, 2, 1000);
    check_gaps(5, 1);

    // 2x1 frame, second load lands 200 cycles after LCU0 finishes.
    ld_mode = 2;
    run_frame(2, 1, 1000);
    check_gaps(1, 200);
    ld_mode = 0;

    // Wrong newblock count on LCU0: blk_err rises and stays set.
    nb_q.push_back(64);
    nb_q.push_back(65);
    run_frame(2, 1, 0);
    check("blk_err_sticky_idle", blk_err, 1);

    // Load completes in the finish cycle: next LCU after a single idle cycle.
    ld_mode = 1;
    run_frame(2, 1, 1000);
    check_gaps(1, 1);
    ld_mode = 0;

    // Reset during LCU0 of a 2x2 frame, then a clean rerun.
    exp_ld.push_back({7'd0, 7'd0, 1'b0});
    exp_ld.push_back({7'd1, 7'd0, 1'b1});
    pulse_start(2, 2);
    n = 0;
    while (!ctrl_enable && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("enable_before_reset", ctrl_enable, 1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset_mid_run_outputs", out_vec(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("loads_before_reset", exp_ld.size(), 0);
    exp_ld.delete();
    run_frame(2, 2, 1000);
    check_gaps(3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
